maze_move_arbiter: RTL and testbench

//  Sequences all sprite moves through the maze. Player (req 0) and enemy (req 1) post one-step

---
 rtl/maze_move_arbiter_if.sv | 26 ++
 rtl/maze_move_arbiter.sv | 166 ++++++++++++++++
 tb/tb_maze_move_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/maze_move_arbiter_if.sv
// Move-request, collision-map and sprite-position bundle for the maze move arbiter.
// The arbiter uses the slave modport; the sprite controllers and map ROM sit on master.
interface maze_move_arbiter_if;
  logic [1:0]  req;
  logic [3:0]  dir0;
  logic [3:0]  dir1;
  logic [1:0]  ack;
  logic        blocked;
  logic        collide;
  logic [8:0]  map_addr;
  logic        map_wall;
  logic [8:0]  p_tile;
  logic [8:0]  e_tile;
  logic [19:0] p_pos;
  logic [19:0] e_pos;

  modport master (
    output req, dir0, dir1, map_wall,
    input  ack, blocked, collide, map_addr, p_tile, e_tile, p_pos, e_pos
  );

  modport slave (
    input  req, dir0, dir1, map_wall,
    output ack, blocked, collide, map_addr, p_tile, e_tile, p_pos, e_pos
  );
endinterface

// File: rtl/maze_move_arbiter.sv
// Round-robin arbiter for player/enemy one-step moves: bounds check, wall lookup through the
// shared collision-map port, sprite-vs-sprite occupancy check, then tile/pixel position commit.
module maze_move_arbiter #(
  parameter int GRID_W     = 20,
  parameter int GRID_H     = 15,
  parameter int TILE_SHIFT = 5,
  parameter int H_ORIGIN   = 144,
  parameter int V_ORIGIN   = 31,
  parameter int P0_X       = 1,
  parameter int P0_Y       = 0,
  parameter int E0_X       = 1,
  parameter int E0_Y       = 1
) (
  input logic           clk,
  input logic           rst,
  maze_move_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CALC, LOOKUP, CHECK, DONE} state_t;

  localparam logic [5:0] GW6 = 6'(GRID_W);
  localparam logic [5:0] GH6 = 6'(GRID_H);
  localparam logic [8:0] GW9 = 9'(GRID_W);
  localparam logic [9:0] HO  = 10'(H_ORIGIN);
  localparam logic [9:0] VO  = 10'(V_ORIGIN);
  localparam logic [4:0] P0X = 5'(P0_X);
  localparam logic [3:0] P0Y = 4'(P0_Y);
  localparam logic [4:0] E0X = 5'(E0_X);
  localparam logic [3:0] E0Y = 4'(E0_Y);

  state_t      state, next_state;
  logic        grant, last_grant, grant_sel;
  logic [3:0]  dir_q;
  logic [4:0]  cur_x, tgt_x, p_x, e_x;
  logic [3:0]  cur_y, tgt_y, p_y, e_y;
  logic        blk_q, col_q;
  logic [8:0]  map_addr_q;
  logic [19:0] p_pos_q, e_pos_q;

  logic        dir_one_hot, illegal, hit_other;
  logic [5:0]  nx, ny;
  logic [8:0]  tgt_addr;
  logic [1:0]  ack_c;
  logic        blocked_c, collide_c;

  function automatic logic [19:0] pixel(input logic [4:0] x, input logic [3:0] y);
    return {HO + (10'(x) << TILE_SHIFT), VO + (10'(y) << TILE_SHIFT)};
  endfunction

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant_sel = 1'b0;
    case (bus.req)
      2'b10:   grant_sel = 1'b1;
      2'b11:   grant_sel = ~last_grant;
      default: grant_sel = 1'b0;
    endcase
  end

  // Stepping below zero wraps the 6-bit coordinate high, so one unsigned compare covers both edges.
  always_comb begin
    dir_one_hot = (dir_q != 4'd0) && ((dir_q & (dir_q - 4'd1)) == 4'd0);
    nx          = {1'b0, cur_x} + 6'(dir_q[0]) - 6'(dir_q[1]);
    ny          = {2'b00, cur_y} + 6'(dir_q[2]) - 6'(dir_q[3]);
    illegal     = !dir_one_hot || (nx >= GW6) || (ny >= GH6);
    tgt_addr    = 9'(ny[3:0]) * GW9 + 9'(nx[4:0]);
    hit_other   = grant ? ({tgt_x, tgt_y} == {p_x, p_y}) : ({tgt_x, tgt_y} == {e_x, e_y});
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.req != 2'b00) next_state = CALC;
      CALC:    next_state = illegal ? DONE : LOOKUP;
      LOOKUP:  next_state = CHECK;
      CHECK:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ack_c     = 2'b00;
    blocked_c = 1'b0;
    collide_c = 1'b0;
    if (state == DONE) begin
      ack_c     = grant ? 2'b10 : 2'b01;
      blocked_c = blk_q;
      collide_c = col_q;
    end
  end

  // Move datapath: the granted sprite's dir and tile are frozen at grant so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      dir_q      <= 4'd0;
      cur_x      <= 5'd0;
      cur_y      <= 4'd0;
      tgt_x      <= 5'd0;
      tgt_y      <= 4'd0;
      blk_q      <= 1'b0;
      col_q      <= 1'b0;
      map_addr_q <= 9'd0;
      p_x        <= P0X;
      p_y        <= P0Y;
      e_x        <= E0X;
      e_y        <= E0Y;
      p_pos_q    <= pixel(P0X, P0Y);
      e_pos_q    <= pixel(E0X, E0Y);
    end else begin
      case (state)
        IDLE: begin
          if (bus.req != 2'b00) begin
            grant <= grant_sel;
            dir_q <= grant_sel ? bus.dir1 : bus.dir0;
            cur_x <= grant_sel ? e_x : p_x;
            cur_y <= grant_sel ? e_y : p_y;
            blk_q <= 1'b0;
            col_q <= 1'b0;
          end
        end
        CALC: begin
          tgt_x <= nx[4:0];
          tgt_y <= ny[3:0];
          if (illegal) blk_q      <= 1'b1;
          else         map_addr_q <= tgt_addr;
        end
        CHECK: begin
          if (bus.map_wall) begin
            blk_q <= 1'b1;
          end else if (hit_other) begin
            blk_q <= 1'b1;
            col_q <= 1'b1;
          end else if (grant) begin
            e_x     <= tgt_x;
            e_y     <= tgt_y;
            e_pos_q <= pixel(tgt_x, tgt_y);
          end else begin
            p_x     <= tgt_x;
            p_y     <= tgt_y;
            p_pos_q <= pixel(tgt_x, tgt_y);
          end
        end
        DONE: last_grant <= grant;
        default: ;
      endcase
    end
  end

  assign bus.ack      = ack_c;
  assign bus.blocked  = blocked_c;
  assign bus.collide  = collide_c;
  assign bus.map_addr = map_addr_q;
  assign bus.p_tile   = {p_x, p_y};
  assign bus.e_tile   = {e_x, e_y};
  assign bus.p_pos    = p_pos_q;
  assign bus.e_pos    = e_pos_q;

endmodule

// File: tb/tb_maze_move_arbiter.sv
// Self-checking bench for maze_move_arbiter: directed scenarios plus random moves scored
// against a tile-level model of the maze with a registered collision-map ROM.
module tb_maze_move_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  maze_move_arbiter_if bus();

  maze_move_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Collision map ROM with one cycle of read latency.
  bit         wall_mem [0:511];
  logic [8:0] addr_d;
  always @(posedge clk) addr_d <= bus.map_addr;
  assign bus.map_wall = wall_mem[addr_d];

  // Reference model state in plain tile coordinates.
  int m_px, m_py, m_ex, m_ey, m_last, m_addr;

  function automatic logic [19:0] exp_pix(input int x, input int y);
    return {10'(144 + x * 32), 10'(31 + y * 32)};
  endfunction

  function automatic logic [8:0] exp_tile(input int x, input int y);
    return {5'(x), 4'(y)};
  endfunction

  task automatic model_reset();
    m_px = 1; m_py = 0; m_ex = 1; m_ey = 1; m_last = 1; m_addr = 0;
  endtask

  task automatic clear_walls();
    for (int i = 0; i < 512; i++) wall_mem[i] = 1'b0;
  endtask

  // Applies one move to the model and reports the expected latency and verdict.
  task automatic model_move(input int who, input logic [3:0] d,
                            output int lat, output bit blk, output bit col);
    int x, y, tx, ty, ox, oy;
    bit legal;
    x  = (who == 1) ? m_ex : m_px;
    y  = (who == 1) ? m_ey : m_py;
    ox = (who == 1) ? m_px : m_ex;
    oy = (who == 1) ? m_py : m_ey;
    tx = x; ty = y;
    legal = ($countones(d) == 1);
    if (d == 4'b1000) ty = y - 1;
    if (d == 4'b0100) ty = y + 1;
    if (d == 4'b0010) tx = x - 1;
    if (d == 4'b0001) tx = x + 1;
    legal = legal && tx >= 0 && tx < 20 && ty >= 0 && ty < 15;
    blk = 1'b0; col = 1'b0;
    if (!legal) begin
      lat = 2; blk = 1'b1;
    end else begin
      lat = 4;
      m_addr = ty * 20 + tx;
      if (wall_mem[m_addr]) blk = 1'b1;
      else if (tx == ox && ty == oy) begin blk = 1'b1; col = 1'b1; end
      else if (who == 1) begin m_ex = tx; m_ey = ty; end
      else begin m_px = tx; m_py = ty; end
    end
    m_last = who;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.req = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Drives a single-requester move, scrambling dir after grant, and scores the acknowledgement.
  task automatic run_move(input int who, input logic [3:0] d, input string tag);
    int lat, n;
    bit blk, col;
    logic [1:0] exp_ack;
    model_move(who, d, lat, blk, col);
    exp_ack = (who == 1) ? 2'b10 : 2'b01;
    if (who == 1) bus.dir1 = d; else bus.dir0 = d;
    bus.req[who] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        bus.dir0 = 4'($urandom);
        bus.dir1 = 4'($urandom);
        if ($urandom_range(0, 1) == 1) bus.req[who] = 1'b0;
      end
    end while (bus.ack == 2'b00 && n < 12);
    bus.req = 2'b00;
    checks++; if (n !== lat) begin errors++; $display("[TB] FAIL %s latency: got %0d want %0d", tag, n, lat); end
    checks++; if (bus.ack !== exp_ack) begin errors++; $display("[TB] FAIL %s ack: got %b want %b", tag, bus.ack, exp_ack); end
    checks++; if (bus.blocked !== blk) begin errors++; $display("[TB] FAIL %s blocked: got %b want %b", tag, bus.blocked, blk); end
    checks++; if (bus.collide !== col) begin errors++; $display("[TB] FAIL %s collide: got %b want %b", tag, bus.collide, col); end
    checks++; if (bus.map_addr !== 9'(m_addr)) begin errors++; $display("[TB] FAIL %s map_addr: got %0d want %0d", tag, bus.map_addr, m_addr); end
    checks++; if (bus.p_tile !== exp_tile(m_px, m_py)) begin errors++; $display("[TB] FAIL %s p_tile: got %h want %h", tag, bus.p_tile, exp_tile(m_px, m_py)); end
    checks++; if (bus.e_tile !== exp_tile(m_ex, m_ey)) begin errors++; $display("[TB] FAIL %s e_tile: got %h want %h", tag, bus.e_tile, exp_tile(m_ex, m_ey)); end
    checks++; if (bus.p_pos !== exp_pix(m_px, m_py)) begin errors++; $display("[TB] FAIL %s p_pos: got %h want %h", tag, bus.p_pos, exp_pix(m_px, m_py)); end
    checks++; if (bus.e_pos !== exp_pix(m_ex, m_ey)) begin errors++; $display("[TB] FAIL %s e_pos: got %h want %h", tag, bus.e_pos, exp_pix(m_ex, m_ey)); end
    @(posedge clk); #1;
    checks++; if (bus.ack !== 2'b00) begin errors++; $display("[TB] FAIL %s ack_pulse: got %b want 00", tag, bus.ack); end
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (bus.p_pos !== {10'd176, 10'd31}) begin errors++; $display("[TB] FAIL reset p_pos: got %h want %h", bus.p_pos, {10'd176, 10'd31}); end
    checks++; if (bus.e_pos !== {10'd176, 10'd63}) begin errors++; $display("[TB] FAIL reset e_pos: got %h want %h", bus.e_pos, {10'd176, 10'd63}); end
    checks++; if (bus.p_tile !== {5'd1, 4'd0}) begin errors++; $display("[TB] FAIL reset p_tile: got %h want %h", bus.p_tile, {5'd1, 4'd0}); end
    checks++; if (bus.e_tile !== {5'd1, 4'd1}) begin errors++; $display("[TB] FAIL reset e_tile: got %h want %h", bus.e_tile, {5'd1, 4'd1}); end
    checks++; if ({bus.ack, bus.blocked, bus.collide} !== 4'b0000) begin errors++; $display("[TB] FAIL reset flags: got %b want 0000", {bus.ack, bus.blocked, bus.collide}); end
    checks++; if (bus.map_addr !== 9'd0) begin errors++; $display("[TB] FAIL reset map_addr: got %0d want 0", bus.map_addr); end
  endtask

  task automatic test_move_right();
    clear_walls();
    run_move(0, 4'b0001, "right");
    checks++; if (bus.p_pos[19:10] !== 10'd208) begin errors++; $display("[TB] FAIL right hpos: got %0d want 208", bus.p_pos[19:10]); end
  endtask

  task automatic test_collision();
    reset_dut();
    clear_walls();
    run_move(0, 4'b0100, "onto_enemy");
  endtask

  task automatic test_illegal();
    reset_dut();
    clear_walls();
    run_move(0, 4'b0001, "prep_right");
    run_move(0, 4'b1000, "up_edge");
    run_move(0, 4'b0110, "two_hot");
    run_move(0, 4'b0000, "no_dir");
    run_move(0, 4'b0010, "left1");
    run_move(0, 4'b0010, "left2");
    run_move(0, 4'b0010, "left_edge");
  endtask

  // Both requesters held: grants must alternate starting with the player.
  task automatic test_back_to_back();
    int lat, n, who, exp_n;
    bit blk, col;
    logic [1:0] exp_ack;
    reset_dut();
    clear_walls();
    wall_mem[20] = 1'b1;
    bus.dir0 = 4'b0001;
    bus.dir1 = 4'b0010;
    bus.req  = 2'b11;
    for (int k = 0; k < 4; k++) begin
      who = (m_last == 1) ? 0 : 1;
      model_move(who, (who == 1) ? 4'b0010 : 4'b0001, lat, blk, col);
      exp_n   = (k == 0) ? lat : lat + 1;
      exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (bus.ack == 2'b00 && n < 12);
      if (k == 3) bus.req = 2'b00;
      checks++; if (n !== exp_n) begin errors++; $display("[TB] FAIL b2b%0d latency: got %0d want %0d", k, n, exp_n); end
      checks++; if (bus.ack !== exp_ack) begin errors++; $display("[TB] FAIL b2b%0d ack: got %b want %b", k, bus.ack, exp_ack); end
      checks++; if (bus.blocked !== blk) begin errors++; $display("[TB] FAIL b2b%0d blocked: got %b want %b", k, bus.blocked, blk); end
      checks++; if (bus.collide !== col) begin errors++; $display("[TB] FAIL b2b%0d collide: got %b want %b", k, bus.collide, col); end
    end
    @(posedge clk); #1;
    checks++; if (bus.ack !== 2'b00) begin errors++; $display("[TB] FAIL b2b idle ack: got %b want 00", bus.ack); end
    checks++; if (bus.p_tile !== exp_tile(m_px, m_py)) begin errors++; $display("[TB] FAIL b2b p_tile: got %h want %h", bus.p_tile, exp_tile(m_px, m_py)); end
    checks++; if (bus.e_tile !== exp_tile(m_ex, m_ey)) begin errors++; $display("[TB] FAIL b2b e_tile: got %h want %h", bus.e_tile, exp_tile(m_ex, m_ey)); end
  endtask

  task automatic test_reset_mid_op();
    reset_dut();
    clear_walls();
    run_move(0, 4'b0001, "pre_abort");
    bus.dir0 = 4'b0001;
    bus.req  = 2'b01;
    @(posedge clk); #1;
    checks++; if (bus.ack !== 2'b00) begin errors++; $display("[TB] FAIL abort calc ack: got %b want 00", bus.ack); end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req = 2'b00;
    @(posedge clk); #1;
    checks++; if (bus.ack !== 2'b00) begin errors++; $display("[TB] FAIL abort ack: got %b want 00", bus.ack); end
    rst = 1'b0;
    model_reset();
    checks++; if (bus.p_tile !== {5'd1, 4'd0}) begin errors++; $display("[TB] FAIL abort p_tile: got %h want %h", bus.p_tile, {5'd1, 4'd0}); end
    checks++; if (bus.p_pos !== {10'd176, 10'd31}) begin errors++; $display("[TB] FAIL abort p_pos: got %h want %h", bus.p_pos, {10'd176, 10'd31}); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.ack !== 2'b00) begin errors++; $display("[TB] FAIL abort late ack: got %b want 00", bus.ack); end
    end
    run_move(1, 4'b0001, "after_abort");
  endtask

  task automatic test_random();
    logic [3:0] dirs [11];
    dirs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010,
             4'b0100, 4'b1000, 4'b0000, 4'b0110, 4'b1001};
    reset_dut();
    for (int i = 0; i < 512; i++) wall_mem[i] = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 40; i++)
      run_move(int'($urandom_range(0, 1)), dirs[$urandom_range(0, 10)], "random");
  endtask

  initial begin
    bus.req  = 2'b00;
    bus.dir0 = 4'b0000;
    bus.dir1 = 4'b0000;
    model_reset();
    clear_walls();
    test_reset();
    test_move_right();
    test_collision();
    test_illegal();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
